// File: rtl/window_generator_if.sv
// Pixel stream in, 3x3 neighbourhood out.
// master = pixel source / window consumer side, slave = window generator side.
interface window_generator_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   pixelIn;
    logic                    pixelValid;
    logic                    frameStart;
    logic [9*DATA_WIDTH-1:0] window;
    logic [DATA_WIDTH-1:0]   wCenter;
    logic                    windowValid;
    logic                    frameDone;

    modport master (
        output pixelIn, pixelValid, frameStart,
        input  window, wCenter, windowValid, frameDone
    );

    modport slave (
        input  pixelIn, pixelValid, frameStart,
        output window, wCenter, windowValid, frameDone
    );
endinterface

// File: rtl/window_generator.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line buffers hold the previous two rows; a 3x3 shift array collects one
// column per accepted pixel. Only interior centres are emitted (no padding).
module window_generator #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                clk,
    input  logic                rst,
    window_generator_if.slave   bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] MIN_COL  = COL_W'(2);
    localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(2);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    // Counters hold the position the next accepted pixel will take.
    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [ROW_W-1:0] row_q, row_d, pos_row;

    // Row r-1 and row r-2 storage, indexed by column; not reset (gated on output).
    pix_t lb1_mem [IMG_WIDTH];
    pix_t lb2_mem [IMG_WIDTH];
    pix_t lb_top, lb_mid;

    // Slot k = 3*i + j, same ordering as the packed window output.
    pix_t shift_q [9];
    pix_t shift_d [9];

    logic [9*DATA_WIDTH-1:0] window_q, window_d;
    logic                    window_valid_q, window_valid_d;
    logic                    frame_done_q, frame_done_d;

    logic accept, emit, last_pix;

    // Position of the incoming pixel, next counters, shifted window and output strobes
    always_comb begin
        accept   = bus.pixelValid;
        pos_col  = bus.frameStart ? '0 : col_q;
        pos_row  = bus.frameStart ? '0 : row_q;
        lb_top   = lb2_mem[pos_col];
        lb_mid   = lb1_mem[pos_col];
        last_pix = (pos_row == LAST_ROW) && (pos_col == LAST_COL);
        emit     = accept && (pos_row >= MIN_ROW) && (pos_col >= MIN_COL);

        shift_d        = shift_q;
        col_d          = col_q;
        row_d          = row_q;
        window_d       = window_q;
        window_valid_d = emit;
        frame_done_d   = accept && last_pix;

        if (accept) begin
            // Shift columns left, insert the new column (rows r-2, r-1, r) on the right.
            for (int i = 0; i < 3; i++) begin
                shift_d[3*i]     = shift_q[3*i + 1];
                shift_d[3*i + 1] = shift_q[3*i + 2];
            end
            shift_d[2] = lb_top;
            shift_d[5] = lb_mid;
            shift_d[8] = bus.pixelIn;

            if (last_pix) begin
                col_d = '0;
                row_d = '0;
            end else if (pos_col == LAST_COL) begin
                col_d = '0;
                row_d = pos_row + ROW_W'(1);
            end else begin
                col_d = pos_col + COL_W'(1);
                row_d = pos_row;
            end
        end

        // Output register only moves when a window is emitted, so it holds otherwise.
        if (emit) begin
            for (int k = 0; k < 9; k++) begin
                window_d[k*DATA_WIDTH +: DATA_WIDTH] = shift_d[k];
            end
        end
    end

    // Control state and output registers; reset wins over a simultaneous pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q          <= '0;
            row_q          <= '0;
            window_q       <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Neighbourhood shift array; a pixel arriving with reset is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= shift_d;
        end
    end

    // Line buffers: row r-1 ages into row r-2, the new pixel becomes row r-1
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb2_mem[pos_col] <= lb_mid;
            lb1_mem[pos_col] <= bus.pixelIn;
        end
    end

    assign bus.window      = window_q;
    assign bus.wCenter     = window_q[4*DATA_WIDTH +: DATA_WIDTH];
    assign bus.windowValid = window_valid_q;
    assign bus.frameDone   = frame_done_q;
endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator on a 5x4 image with pixel value 16*row+col.
module tb_window_generator;
    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    window_generator_if #(.DATA_WIDTH(DW)) bus ();

    window_generator #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int  cyc = 0;
    int  m_row = 0, m_col = 0;
    int  p22_cyc = 0;
    bit  drv_emit = 1'b0;
    bit  exp_vld = 1'b0;
    bit  rst_seen = 1'b0;
    bit  mon_en = 1'b0;
    int  vld_bad = 0;
    int  hold_bad = 0;
    logic [9*DW-1:0] last_win;

    logic [9*DW-1:0] exp_q[$];
    logic [9*DW-1:0] obs_q[$];
    logic [DW-1:0]   obs_ctr_q[$];
    int              obs_cyc_q[$];
    int              exp_fd_q[$];
    int              fd_q[$];

    logic [DW-1:0] ctr_tab [6] = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};

    // Expected neighbourhood centred on (r-1,c-1) when pixel (r,c) is accepted.
    function automatic logic [9*DW-1:0] win_of(input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*DW +: DW] = DW'(16*(r-2+i) + (c-2+j));
        return w;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        exp_vld  <= drv_emit;
        rst_seen <= rst;
    end

    // Output monitor: collects windows/frameDone, flags unexpected valids and unheld outputs.
    always @(negedge clk) begin
        if (rst_seen) begin
            last_win = '0;
        end else if (mon_en) begin
            if (bus.windowValid !== exp_vld) vld_bad = vld_bad + 1;
            if (bus.windowValid === 1'b1) begin
                obs_q.push_back(bus.window);
                obs_ctr_q.push_back(bus.wCenter);
                obs_cyc_q.push_back(cyc);
                last_win = bus.window;
            end else if (bus.window !== last_win || bus.wCenter !== last_win[39:32]) begin
                hold_bad = hold_bad + 1;
            end
        end
        if (mon_en && bus.frameDone === 1'b1) fd_q.push_back(cyc);
    end

    // Drive one cycle (called at a negedge, returns at the next negedge).
    task automatic drive(input bit v, input bit fs, input bit r, input int off);
        int pr, pc;
        drv_emit       = 1'b0;
        bus.pixelValid = v;
        bus.frameStart = fs;
        bus.pixelIn    = '0;
        rst            = r;
        if (r) begin
            m_row = 0;
            m_col = 0;
            bus.pixelIn = 8'hEE;
        end else if (v) begin
            pr = fs ? 0 : m_row;
            pc = fs ? 0 : m_col;
            bus.pixelIn = DW'(16*pr + pc + off);
            if (pr == 2 && pc == 2) p22_cyc = cyc + 1;
            if (pr >= 2 && pc >= 2) begin
                drv_emit = 1'b1;
                exp_q.push_back(win_of(pr, pc));
            end
            if (pr == H-1 && pc == W-1) exp_fd_q.push_back(cyc + 1);
            if (pc == W-1) begin
                m_col = 0;
                m_row = (pr == H-1) ? 0 : pr + 1;
            end else begin
                m_col = pc + 1;
                m_row = pr;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic clear_sb();
        exp_q.delete(); obs_q.delete(); obs_ctr_q.delete(); obs_cyc_q.delete();
        exp_fd_q.delete(); fd_q.delete();
        vld_bad = 0; hold_bad = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 0);
        drive(1'b1, 1'b1, 1'b1, 0);
        n_checks++; if (bus.windowValid !== 1'b0) begin n_fail++; $display("FAIL reset_windowValid: got %b expected 0", bus.windowValid); end
        n_checks++; if (bus.frameDone !== 1'b0) begin n_fail++; $display("FAIL reset_frameDone: got %b expected 0", bus.frameDone); end
        n_checks++; if (bus.window !== '0) begin n_fail++; $display("FAIL reset_window: got %h expected 0", bus.window); end
        n_checks++; if (bus.wCenter !== '0) begin n_fail++; $display("FAIL reset_wCenter: got %h expected 0", bus.wCenter); end
        mon_en = 1'b1;
        idle(1);
    endtask

    task automatic test_basic_window();
        logic [9*DW-1:0] first_exp;
        first_exp = 72'h22_21_20_12_11_10_02_01_00;
        clear_sb();
        for (int i = 0; i < W*H; i++) drive(1'b1, 1'b0, 1'b0, 0);
        idle(3);
        n_checks++; if (obs_cyc_q.size() == 0 || obs_cyc_q[0] != p22_cyc) begin n_fail++; $display("FAIL basic_first_cycle: got %0d expected %0d", (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1, p22_cyc); end
        n_checks++; if (obs_q.size() == 0 || obs_q[0] !== first_exp) begin n_fail++; $display("FAIL basic_window: got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : '0, first_exp); end
        n_checks++; if (obs_ctr_q.size() == 0 || obs_ctr_q[0] !== 8'h11) begin n_fail++; $display("FAIL basic_wCenter: got %h expected 11", (obs_ctr_q.size() > 0) ? obs_ctr_q[0] : 8'h00); end
    endtask

    task automatic test_count_order();
        clear_sb();
        for (int i = 0; i < W*H; i++) drive(1'b1, 1'b0, 1'b0, 0);
        idle(3);
        n_checks++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL count_windows: got %0d expected 6", obs_q.size()); end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL count_window_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
            n_checks++; if (obs_ctr_q[i] !== ctr_tab[i]) begin n_fail++; $display("FAIL count_centre_%0d: got %h expected %h", i, obs_ctr_q[i], ctr_tab[i]); end
        end
        n_checks++; if (fd_q.size() != 1) begin n_fail++; $display("FAIL count_frameDone_pulses: got %0d expected 1", fd_q.size()); end
        n_checks++; if (fd_q.size() < 1 || fd_q[0] != exp_fd_q[0]) begin n_fail++; $display("FAIL count_frameDone_cycle: got %0d expected %0d", (fd_q.size() > 0) ? fd_q[0] : -1, exp_fd_q[0]); end
        n_checks++; if (vld_bad != 0) begin n_fail++; $display("FAIL count_valid_timing: got %0d bad cycles expected 0", vld_bad); end
    endtask

    task automatic test_gaps();
        clear_sb();
        for (int i = 0; i < W*H; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0);
            repeat ($urandom_range(0, 5)) drive(1'b0, ($urandom_range(0, 2) == 0), 1'b0, 0);
        end
        idle(3);
        n_checks++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL gaps_windows: got %0d expected 6", obs_q.size()); end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gaps_window_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (vld_bad != 0) begin n_fail++; $display("FAIL gaps_valid_in_idle: got %0d bad cycles expected 0", vld_bad); end
        n_checks++; if (hold_bad != 0) begin n_fail++; $display("FAIL gaps_hold: got %0d changed cycles expected 0", hold_bad); end
        n_checks++; if (fd_q.size() != 1) begin n_fail++; $display("FAIL gaps_frameDone: got %0d expected 1", fd_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        clear_sb();
        for (int i = 0; i < 13; i++) drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1, 0);
        n_checks++; if (bus.windowValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_windowValid: got %b expected 0", bus.windowValid); end
        n_checks++; if (bus.window !== '0) begin n_fail++; $display("FAIL rstmid_window: got %h expected 0", bus.window); end
        n_checks++; if (bus.wCenter !== '0) begin n_fail++; $display("FAIL rstmid_wCenter: got %h expected 0", bus.wCenter); end
        idle(2);
        clear_sb();
        for (int i = 0; i < W*H; i++) drive(1'b1, 1'b0, 1'b0, 0);
        idle(3);
        n_checks++; if (obs_cyc_q.size() == 0 || obs_cyc_q[0] != p22_cyc) begin n_fail++; $display("FAIL rstmid_first_cycle: got %0d expected %0d", (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1, p22_cyc); end
        n_checks++; if (obs_ctr_q.size() == 0 || obs_ctr_q[0] !== 8'h11) begin n_fail++; $display("FAIL rstmid_first_centre: got %h expected 11", (obs_ctr_q.size() > 0) ? obs_ctr_q[0] : 8'h00); end
        n_checks++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL rstmid_windows: got %0d expected 6", obs_q.size()); end
    endtask

    task automatic test_frame_start();
        clear_sb();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 8'h80);
        drive(1'b1, 1'b1, 1'b0, 0);
        for (int i = 1; i < W*H; i++) drive(1'b1, 1'b0, 1'b0, 0);
        idle(3);
        n_checks++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL fstart_windows: got %0d expected 6", obs_q.size()); end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fstart_window_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (fd_q.size() != 1) begin n_fail++; $display("FAIL fstart_frameDone: got %0d expected 1", fd_q.size()); end
        n_checks++; if (vld_bad != 0) begin n_fail++; $display("FAIL fstart_valid_timing: got %0d bad cycles expected 0", vld_bad); end
    endtask

    task automatic test_simultaneous();
        clear_sb();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b1, 0);
        n_checks++; if (bus.windowValid !== 1'b0 || bus.window !== '0) begin n_fail++; $display("FAIL simul_outputs: got %b/%h expected 0/0", bus.windowValid, bus.window); end
        clear_sb();
        for (int i = 0; i < W*H; i++) drive(1'b1, 1'b0, 1'b0, 0);
        idle(3);
        n_checks++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL simul_windows: got %0d expected 6", obs_q.size()); end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL simul_window_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (fd_q.size() != 1 || fd_q[0] != exp_fd_q[0]) begin n_fail++; $display("FAIL simul_frameDone: got %0d pulses expected 1 at cycle %0d", fd_q.size(), exp_fd_q[0]); end
    endtask

    initial begin
        bus.pixelIn    = '0;
        bus.pixelValid = 1'b0;
        bus.frameStart = 1'b0;
        test_reset();
        test_basic_window();
        test_count_order();
        test_gaps();
        test_reset_mid_frame();
        test_frame_start();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bit width of each pixel.
REQ-002 Parameter IMG_WIDTH, default 64, SHALL set the pixels per line (minimum 3).
REQ-003 Parameter IMG_HEIGHT, default 64, SHALL set the lines per frame (minimum 3).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 pixelIn  input  DATA_WIDTH  SHALL carry the raster-order pixel; it is sampled only when pixelValid=1.
REQ-007 pixelValid  input  1  SHALL qualify pixelIn; there is no backpressure.
REQ-008 frameStart  input  1  SHALL, when high with pixelValid, mark the accepted pixel as (row 0, col 0).
REQ-009 window  output  9*DATA_WIDTH  SHALL carry the 3x3 neighbourhood; slot k=3*i+j occupies bits [k*DATA_WIDTH +: DATA_WIDTH], where i is the row (0=top) and j is the column (0=left).
REQ-010 wCenter  output  DATA_WIDTH  SHALL equal window slot 4 and feed the noise detection stage.
REQ-011 windowValid  output  1  SHALL qualify window and wCenter for one cycle.
REQ-012 frameDone  output  1  SHALL pulse for one cycle after the last pixel of a frame is accepted.

Function
REQ-013 Accepted pixels SHALL advance column counter col (0..IMG_WIDTH-1); on wrap, col returns to 0 and row (0..IMG_HEIGHT-1) increments.
REQ-014 Two line buffers of IMG_WIDTH entries SHALL hold rows r-1 and r-2; a 3x3 register array SHALL shift one column per accepted pixel.
REQ-015 Accepting pixel (r,c) with r>=2 and c>=2 SHALL cause the following outputs on the next cycle:
  - windowValid=1;
  - the window centred on (r-1,c-1), slot (i,j) = pixel (r-2+i, c-2+j).
REQ-016 Window emission SHALL be limited to interior centres only: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, with no border padding.
REQ-017 windowValid SHALL be 0 in every cycle not covered by REQ-015, including all cycles with pixelValid=0.
REQ-018 window and wCenter SHALL hold their last value while windowValid=0.
REQ-019 Gaps in pixelValid of any length SHALL NOT alter counters, buffers or the window content sequence.
REQ-020 When the accepted pixel is (IMG_HEIGHT-1, IMG_WIDTH-1), the following SHALL happen:
  - frameDone=1 on the next cycle;
  - row and col SHALL return to 0.
REQ-021 frameStart with pixelValid SHALL force that pixel to (0,0) regardless of the current counters.
  - The next pixel SHALL be (0,1).
  - No window SHALL use pre-frameStart data.
  - No frameDone SHALL be generated for the aborted frame.
REQ-022 frameStart with pixelValid=0 SHALL be ignored.
REQ-023 Pixel values SHALL pass through unmodified, with no arithmetic, truncation or reordering.

Reset
REQ-024 While rst=1 the block SHALL set the following on the next edge:
  - row=0, col=0;
  - windowValid=0, frameDone=0;
  - window=0, wCenter=0.
REQ-025 rst SHALL take priority over a simultaneous pixelValid or frameStart; that pixel is discarded.
REQ-026 Line buffer contents need not be cleared; REQ-015 gating SHALL guarantee that stale data is never emitted.
REQ-027 The first pixel accepted after rst deasserts SHALL be treated as (0,0).

Verification
REQ-028 The bench SHALL use IMG_WIDTH=5, IMG_HEIGHT=4 and pixel value = 16*r+c, and SHALL cover the following scenarios:
  - Basic window: stream 20 pixels continuously -> the first windowValid occurs the cycle after pixel index 12; window = 00,01,02,10,11,12,20,21,22 and wCenter=0x11.
  - Window count and order: the full frame -> exactly 6 windowValid pulses with centres 0x11,0x12,0x13,0x21,0x22,0x23; frameDone pulses once, the cycle after pixel 0x34.
  - Input gaps: the same frame with random pixelValid gaps of 0-5 cycles -> an identical window sequence; windowValid never high during idle cycles.
  - Reset mid-frame: rst asserted after pixel 0x22 -> outputs zero next cycle; a new frame after reset yields its first window centre 0x11 only after that frame's pixel index 12.
  - frameStart mid-frame: frameStart after 8 pixels -> no window from the partial data; the resynchronised frame yields the correct 6 windows and one frameDone.
  - Simultaneous events: rst and pixelValid high together -> the pixel is dropped and the counters read (0,0).
